// File: rtl/matrix_fetch_pkg.sv
// ---------------------------------------------------------------------------
// mat_pkg
// Shared definitions for the matrix datapath blocks (matrix_fetch,
// matrix_printer, uart_parser): element/bus geometry, error codes, the fetch
// state encoding and a dimension range check.
// ---------------------------------------------------------------------------
package mat_pkg;

   localparam int DATAWIDTH = 8;                       // bits per element
   localparam int MAXDIM    = 5;                       // max rows / columns
   localparam int IDXW      = 2;                       // matrix index width
   localparam int DIMW      = 3;                       // width of m / n / row / col
   localparam int NELEM     = MAXDIM * MAXDIM;         // slots on the flat bus
   localparam int FLATW     = NELEM * DATAWIDTH;       // 200-bit flat payload

   typedef logic [1:0] err_code_t;

   localparam err_code_t ERR_NONE    = 2'd0;
   localparam err_code_t ERR_DIM     = 2'd1;
   localparam err_code_t ERR_STORE   = 2'd2;
   localparam err_code_t ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      REQ,
      WAIT,
      STREAM,
      DONE,
      ERR
   } fetch_state_t;

   // A shape is usable only when both dimensions are in 1..MAXDIM.
   function automatic logic dims_valid(input logic [DIMW-1:0] m,
                                       input logic [DIMW-1:0] n);
      return (m != '0) && (n != '0) &&
             (m <= DIMW'(MAXDIM)) && (n <= DIMW'(MAXDIM));
   endfunction

endpackage

// File: rtl/matrix_fetch_if.sv
// ---------------------------------------------------------------------------
// matrix_fetch_if
// Bundles the two handshakes of the fetch unit:
//   storage read port : read_en, rd_col, rd_row, rd_mat_index (to storage),
//                       rd_data_flow, rd_ready, err_rd (from storage)
//   element stream    : elem_data, elem_valid, elem_last, elem_row, elem_col
//                       (to consumer), elem_ready (from consumer)
// master = the fetch unit, slave = storage model plus stream consumer.
// ---------------------------------------------------------------------------
interface matrix_fetch_if;
   import mat_pkg::*;

   logic                 read_en;
   logic [DIMW-1:0]      rd_col;
   logic [DIMW-1:0]      rd_row;
   logic [IDXW-1:0]      rd_mat_index;
   logic [FLATW-1:0]     rd_data_flow;
   logic                 rd_ready;
   logic                 err_rd;

   logic [DATAWIDTH-1:0] elem_data;
   logic                 elem_valid;
   logic                 elem_ready;
   logic                 elem_last;
   logic [DIMW-1:0]      elem_row;
   logic [DIMW-1:0]      elem_col;

   modport master (
      output read_en, rd_col, rd_row, rd_mat_index,
      input  rd_data_flow, rd_ready, err_rd,
      output elem_data, elem_valid, elem_last, elem_row, elem_col,
      input  elem_ready
   );

   modport slave (
      input  read_en, rd_col, rd_row, rd_mat_index,
      output rd_data_flow, rd_ready, err_rd,
      input  elem_data, elem_valid, elem_last, elem_row, elem_col,
      output elem_ready
   );

endinterface

// File: rtl/matrix_fetch_cursor.sv
// ---------------------------------------------------------------------------
// elem_cursor
// Row/column walker over a row-major matrix held on the flat bus.
//   clk, rst      : clock, synchronous active-high reset
//   load          : restart at (0,0)
//   advance       : step to the next element (col first, wraps into row)
//   dim_m, dim_n  : matrix shape
//   flat          : flat payload, element k = r*n + c at bits [8k+7:8k]
//   row, col      : current position
//   last          : current position is (m-1, n-1)
//   data          : element at the current position
// ---------------------------------------------------------------------------
module elem_cursor
   import mat_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 advance,
   input  logic [DIMW-1:0]      dim_m,
   input  logic [DIMW-1:0]      dim_n,
   input  logic [FLATW-1:0]     flat,
   output logic [DIMW-1:0]      row,
   output logic [DIMW-1:0]      col,
   output logic                 last,
   output logic [DATAWIDTH-1:0] data
);

   localparam int KW   = 2 * DIMW;
   localparam int SELW = $clog2(NELEM);

   logic [DIMW-1:0]      row_reg, row_next;
   logic [DIMW-1:0]      col_reg, col_next;
   logic                 row_end;
   logic [KW-1:0]        k;
   logic [DATAWIDTH-1:0] elems [NELEM];

   // Slice the flat bus into addressable elements.
   genvar gi;
   generate
      for (gi = 0; gi < NELEM; gi++) begin : g_slice
         assign elems[gi] = flat[gi*DATAWIDTH +: DATAWIDTH];
      end
   endgenerate

   assign row_end = (col_reg == dim_n - 1'b1);
   assign last    = row_end && (row_reg == dim_m - 1'b1);

   always_comb begin
      row_next = row_reg;
      col_next = col_reg;
      if (load) begin
         row_next = '0;
         col_next = '0;
      end else if (advance) begin
         if (last) begin
            // Park at the origin so a reused cursor starts clean.
            row_next = '0;
            col_next = '0;
         end else if (row_end) begin
            row_next = row_reg + 1'b1;
            col_next = '0;
         end else begin
            col_next = col_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_reg <= '0;
         col_reg <= '0;
      end else begin
         row_reg <= row_next;
         col_reg <= col_next;
      end
   end

   // Linear index is computed with the runtime column count, not MAXDIM.
   assign k    = KW'(row_reg) * KW'(dim_n) + KW'(col_reg);
   assign data = (k < KW'(NELEM)) ? elems[k[SELW-1:0]] : '0;
   assign row  = row_reg;
   assign col  = col_reg;

endmodule

// File: rtl/matrix_fetch.sv
// ---------------------------------------------------------------------------
// matrix_fetch
// Reads one stored matrix selected by (m, n, index) from matrix storage,
// latches the flat payload and streams its elements row-major over a
// valid/ready handshake. Storage errors, bad shapes and a missing storage
// response are reported as a one-cycle error pulse with a held error code.
//   clk, rst              : clock, synchronous active-high reset
//   start                 : fetch request, honoured only when idle
//   req_m, req_n, req_idx : requested shape and index
//   bus (master)          : storage read port and element stream
//   matrix_flat           : last successfully captured payload
//   dim_m, dim_n          : shape of that payload
//   busy                  : any state other than IDLE
//   done, error           : one-cycle completion / failure pulses
//   err_code              : 0 none, 1 bad dims, 2 storage error, 3 timeout
// ---------------------------------------------------------------------------
module matrix_fetch
   import mat_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DIMW-1:0]   req_m,
   input  logic [DIMW-1:0]   req_n,
   input  logic [IDXW-1:0]   req_idx,
   matrix_fetch_if.master    bus,
   output logic [FLATW-1:0]  matrix_flat,
   output logic [DIMW-1:0]   dim_m,
   output logic [DIMW-1:0]   dim_n,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [1:0]        err_code
);

   localparam int CNTW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 2;

   fetch_state_t         state_reg, state_next;
   logic [CNTW-1:0]      cnt_reg, cnt_next;
   err_code_t            err_code_reg, err_code_next;
   logic [DIMW-1:0]      m_reg, n_reg;
   logic [IDXW-1:0]      idx_reg;
   logic [FLATW-1:0]     flat_reg;
   logic [DIMW-1:0]      dim_m_reg, dim_n_reg;

   logic                 latch_req;
   logic                 capture;
   logic                 advance;
   logic                 streaming;
   logic [DIMW-1:0]      cur_row, cur_col;
   logic                 cur_last;
   logic [DATAWIDTH-1:0] cur_data;

   // ---------------- state register and datapath registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         err_code_reg <= ERR_NONE;
         m_reg        <= '0;
         n_reg        <= '0;
         idx_reg      <= '0;
         flat_reg     <= '0;
         dim_m_reg    <= '0;
         dim_n_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         err_code_reg <= err_code_next;
         if (latch_req) begin
            m_reg   <= req_m;
            n_reg   <= req_n;
            idx_reg <= req_idx;
         end
         if (capture) begin
            flat_reg  <= bus.rd_data_flow;
            dim_m_reg <= m_reg;
            dim_n_reg <= n_reg;
         end
      end
   end

   // ---------------- next state and strobes ----------------
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      err_code_next = err_code_reg;
      latch_req     = 1'b0;
      capture       = 1'b0;
      advance       = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               latch_req     = 1'b1;
               err_code_next = ERR_NONE;
               state_next    = CHECK;
            end
         end
         CHECK: begin
            if (dims_valid(m_reg, n_reg)) begin
               state_next = REQ;
            end else begin
               err_code_next = ERR_DIM;
               state_next    = ERR;
            end
         end
         REQ: begin
            cnt_next   = '0;
            state_next = WAIT;
         end
         WAIT: begin
            cnt_next = cnt_reg + 1'b1;
            // err_rd has priority over a simultaneous rd_ready.
            if (bus.err_rd) begin
               err_code_next = ERR_STORE;
               state_next    = ERR;
            end else if (bus.rd_ready) begin
               capture    = 1'b1;
               state_next = STREAM;
            end else if (cnt_reg == CNTW'(TIMEOUT - 2)) begin
               // Counter is about to reach TIMEOUT-1: the error pulse then
               // lands exactly TIMEOUT cycles after the read_en cycle.
               err_code_next = ERR_TIMEOUT;
               state_next    = ERR;
            end
         end
         STREAM: begin
            if (bus.elem_ready) begin
               advance = 1'b1;
               if (cur_last) begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- element cursor ----------------
   elem_cursor u_cursor (
      .clk     (clk),
      .rst     (rst),
      .load    (capture),
      .advance (advance),
      .dim_m   (dim_m_reg),
      .dim_n   (dim_n_reg),
      .flat    (flat_reg),
      .row     (cur_row),
      .col     (cur_col),
      .last    (cur_last),
      .data    (cur_data)
   );

   // ---------------- outputs ----------------
   assign streaming        = (state_reg == STREAM);

   assign bus.read_en      = (state_reg == REQ);
   assign bus.rd_col       = m_reg;
   assign bus.rd_row       = n_reg;
   assign bus.rd_mat_index = idx_reg;

   // Stream fields read as zero whenever no element is on offer.
   assign bus.elem_valid   = streaming;
   assign bus.elem_data    = streaming ? cur_data : '0;
   assign bus.elem_row     = streaming ? cur_row  : '0;
   assign bus.elem_col     = streaming ? cur_col  : '0;
   assign bus.elem_last    = streaming && cur_last;

   assign matrix_flat      = flat_reg;
   assign dim_m            = dim_m_reg;
   assign dim_n            = dim_n_reg;
   assign busy             = (state_reg != IDLE);
   assign done             = (state_reg == DONE);
   assign error            = (state_reg == ERR);
   assign err_code         = err_code_reg;

endmodule
